// File: rtl/dfd_time_tick_gen.sv
// -----------------------------------------------------------------------------
// dfd_time_tick_gen
//   Produces the time-tick increment strobe and the cross-trigger resync pulse
//   for the DFD timestamp stage.
//
//   Tick source: a fractional accumulator (INC/MOD ticks per clock) or an
//   external reference tick, which is synchronized and rising-edge detected.
//   Cross-trigger: synchronized, rising-edge detected, stretched to STRETCH
//   cycles and followed by a programmable holdoff.
//
//   Optional feature macro: DFD_TIME_TICK_GEN_STATS_EN
//     defined   -> saturating 32-bit tick counter on o_tick_count
//     undefined -> o_tick_count tied to zero, no counter flops
// -----------------------------------------------------------------------------
module dfd_time_tick_gen #(
    parameter int ACC_W    = 16,
    parameter int STRETCH  = 2,
    parameter int HOLD_W   = 16,
    parameter int SYNC_STG = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_ext_sel,
    input  logic [ACC_W-1:0]  i_inc,
    input  logic [ACC_W-1:0]  i_mod,
    input  logic              i_ext_tick,
    input  logic              i_trig_in,
    input  logic [HOLD_W-1:0] i_trig_holdoff,
    input  logic              i_stats_clr,
    output logic              o_time_tick,
    output logic              o_xtrigger,
    output logic              o_cfg_err,
    output logic [31:0]       o_tick_count
);

    // Stretch counter only has to hold STRETCH-1.
    localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_INT = 2'd1,
        RUN_EXT = 2'd2
    } tick_state_e;

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_ACTIVE = 2'd1,
        T_HOLD   = 2'd2
    } trig_state_e;

    // -------------------------------------------------------------------------
    // Synchronizers and edge detectors
    //   Bits [SYNC_STG-1:0] are the synchronizer proper; bit [SYNC_STG] holds
    //   the previous synchronized value for the rising-edge compare. The edge
    //   pulse is registered, giving SYNC_STG+2 cycles from the async edge to
    //   the registered output that reacts to it.
    // -------------------------------------------------------------------------
    logic [SYNC_STG:0] ext_sync_q;
    logic [SYNC_STG:0] trig_sync_q;
    logic              ext_edge_q;
    logic              trig_edge_q;

    // Shift both async inputs through their synchronizers every cycle, in every state.
    always_ff @(posedge i_clk) begin
        // NOTE: synchronous reset lives inside the clocked block and every
        // sequential assignment is non-blocking, so all flops update together.
        if (i_reset) begin
            ext_sync_q  <= '0;
            trig_sync_q <= '0;
            ext_edge_q  <= 1'b0;
            trig_edge_q <= 1'b0;
        end else begin
            ext_sync_q  <= {ext_sync_q[SYNC_STG-1:0], i_ext_tick};
            trig_sync_q <= {trig_sync_q[SYNC_STG-1:0], i_trig_in};
            ext_edge_q  <= ext_sync_q[SYNC_STG-1] & ~ext_sync_q[SYNC_STG];
            trig_edge_q <= trig_sync_q[SYNC_STG-1] & ~trig_sync_q[SYNC_STG];
        end
    end

    // -------------------------------------------------------------------------
    // Fractional accumulator datapath
    //   The sum is one bit wider than the accumulator so acc+inc never wraps.
    //   With inc <= mod (guaranteed whenever the FSM uses acc_d), sum-mod is
    //   bounded by acc and always fits back into ACC_W bits.
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;
    logic             wrap;
    logic             cfg_err;

    // Next accumulator value and wrap (tick) decision for the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no
        // latch can be inferred.
        cfg_err = (i_mod == '0) || (i_inc > i_mod);
        sum     = {1'b0, acc_q} + {1'b0, i_inc};
        wrap    = (sum >= {1'b0, i_mod});
        acc_d   = wrap ? ACC_W'(sum - {1'b0, i_mod}) : ACC_W'(sum);
    end

    // -------------------------------------------------------------------------
    // Tick FSM
    //   Every mode change passes through IDLE, which clears the accumulator,
    //   so each run starts from a full period. Leaving a run state takes
    //   priority over a tick in the same cycle.
    // -------------------------------------------------------------------------
    tick_state_e tick_state_q;
    logic        time_tick_q;
    logic        cfg_err_q;

    // Tick mode control, accumulator and registered tick / config-error outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_state_q <= IDLE;
            acc_q        <= '0;
            time_tick_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q   <= cfg_err & i_enable & ~i_ext_sel;
            time_tick_q <= 1'b0;
            case (tick_state_q)
                IDLE: begin
                    acc_q <= '0;
                    if (i_enable && !i_ext_sel && !cfg_err) begin
                        tick_state_q <= RUN_INT;
                    end else if (i_enable && i_ext_sel) begin
                        tick_state_q <= RUN_EXT;
                    end
                end
                RUN_INT: begin
                    if (!i_enable || i_ext_sel || cfg_err) begin
                        tick_state_q <= IDLE;
                        acc_q        <= '0;
                    end else begin
                        acc_q       <= acc_d;
                        time_tick_q <= wrap;
                    end
                end
                RUN_EXT: begin
                    if (!i_enable || !i_ext_sel) begin
                        tick_state_q <= IDLE;
                        acc_q        <= '0;
                    end else begin
                        time_tick_q <= ext_edge_q;
                    end
                end
                default: begin
                    tick_state_q <= IDLE;
                    acc_q        <= '0;
                end
            endcase
        end
    end

    assign o_time_tick = time_tick_q;
    assign o_cfg_err   = cfg_err_q;

    // -------------------------------------------------------------------------
    // Cross-trigger FSM
    //   Runs regardless of i_enable. Edges arriving while the pulse is active
    //   or during holdoff are dropped. The holdoff value is captured when the
    //   pulse ends; T_HOLD lasts holdoff+1 cycles before T_IDLE accepts again.
    // -------------------------------------------------------------------------
    trig_state_e       trig_state_q;
    logic              xtrigger_q;
    logic [SW-1:0]     stretch_q;
    logic [HOLD_W-1:0] hold_q;

    // Accept, stretch and hold off cross-trigger pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            trig_state_q <= T_IDLE;
            xtrigger_q   <= 1'b0;
            stretch_q    <= '0;
            hold_q       <= '0;
        end else begin
            case (trig_state_q)
                T_IDLE: begin
                    if (trig_edge_q) begin
                        trig_state_q <= T_ACTIVE;
                        xtrigger_q   <= 1'b1;
                        stretch_q    <= SW'(STRETCH - 1);
                    end
                end
                T_ACTIVE: begin
                    if (stretch_q == '0) begin
                        trig_state_q <= T_HOLD;
                        xtrigger_q   <= 1'b0;
                        hold_q       <= i_trig_holdoff;
                    end else begin
                        stretch_q <= stretch_q - SW'(1);
                    end
                end
                T_HOLD: begin
                    if (hold_q == '0) begin
                        trig_state_q <= T_IDLE;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    trig_state_q <= T_IDLE;
                    xtrigger_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_xtrigger = xtrigger_q;

    // -------------------------------------------------------------------------
    // Tick statistics
    // -------------------------------------------------------------------------
`ifdef DFD_TIME_TICK_GEN_STATS_EN
    logic [31:0] tick_count_q;

    // Saturating count of emitted ticks; clear beats a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stats_clr) begin
            tick_count_q <= '0;
        end else if (time_tick_q && (tick_count_q != 32'hFFFF_FFFF)) begin
            tick_count_q <= tick_count_q + 32'd1;
        end
    end

    assign o_tick_count = tick_count_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = i_stats_clr;
    assign o_tick_count     = 32'h0;
`endif

endmodule

// File: tb/tb_dfd_time_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_dfd_time_tick_gen
//   Directed scenarios plus a randomized phase. A cycle-level behavioural
//   model (plain integer accumulator, sample-history delay lines, timestamp
//   based trigger windows) predicts every output and is compared on each
//   falling edge. Directed scenarios also pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_dfd_time_tick_gen;

    localparam int ACC_W    = 16;
    localparam int STRETCH  = 2;
    localparam int HOLD_W   = 16;
    localparam int SYNC_STG = 2;

    logic              clk;
    logic              rst;
    logic              en;
    logic              sel;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  mod;
    logic              ext;
    logic              trig;
    logic [HOLD_W-1:0] holdoff;
    logic              clr;
    logic              tick_o;
    logic              xtrig_o;
    logic              cfg_o;
    logic [31:0]       count_o;

    dfd_time_tick_gen #(
        .ACC_W   (ACC_W),
        .STRETCH (STRETCH),
        .HOLD_W  (HOLD_W),
        .SYNC_STG(SYNC_STG)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_ext_sel     (sel),
        .i_inc         (inc),
        .i_mod         (mod),
        .i_ext_tick    (ext),
        .i_trig_in     (trig),
        .i_trig_holdoff(holdoff),
        .i_stats_clr   (clr),
        .o_time_tick   (tick_o),
        .o_xtrigger    (xtrig_o),
        .o_cfg_err     (cfg_o),
        .o_tick_count  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;      // 0 idle, 1 internal, 2 external
    longint      m_acc;
    bit          m_tick;
    bit          m_cfg;
    bit          m_x;
    longint      m_cnt;
    longint      k_cyc;
    longint      act_at;      // edge index at which the current pulse was accepted, -1 if none
    longint      next_acc;    // first edge index at which a new trigger edge is honoured
    bit          ext_h[$];    // raw samples of i_ext_tick, newest last
    bit          trig_h[$];

    initial begin
        m_mode = 0; m_acc = 0; m_tick = 0; m_cfg = 0; m_x = 0; m_cnt = 0;
        k_cyc = 0; act_at = -1; next_acc = 0;
    end

    // Rising edge seen SYNC_STG+1 samples ago, as it becomes usable this cycle.
    function automatic bit hist_edge(input bit h[$]);
        int n;
        n = h.size();
        return h[n-SYNC_STG-1] && !h[n-SYNC_STG-2];
    endfunction

    task automatic model_step();
        bit ee, te, cfg, nt;
        longint s;
        while (ext_h.size() < SYNC_STG + 3) ext_h.push_front(1'b0);
        while (trig_h.size() < SYNC_STG + 3) trig_h.push_front(1'b0);
        ee = hist_edge(ext_h);
        te = hist_edge(trig_h);
        k_cyc++;
        if (rst) begin
            m_mode = 0; m_acc = 0; m_tick = 0; m_cfg = 0; m_x = 0; m_cnt = 0;
            act_at = -1; next_acc = 0;
            foreach (ext_h[i]) ext_h[i] = 1'b0;
            foreach (trig_h[i]) trig_h[i] = 1'b0;
        end else begin
            if (clr) m_cnt = 0;
            else if (m_tick && m_cnt != 64'hFFFF_FFFF) m_cnt++;
            cfg = (mod == 0) || (inc > mod);
            nt  = 1'b0;
            if (m_mode == 0) begin
                m_acc = 0;
                if (en && !sel && !cfg) m_mode = 1;
                else if (en && sel)     m_mode = 2;
            end else if (m_mode == 1) begin
                if (!en || sel || cfg) begin
                    m_mode = 0; m_acc = 0;
                end else begin
                    s = m_acc + longint'(inc);
                    if (s >= longint'(mod)) begin m_acc = s - longint'(mod); nt = 1'b1; end
                    else m_acc = s;
                end
            end else begin
                if (!en || !sel) m_mode = 0;
                else nt = ee;
            end
            m_tick = nt;
            m_cfg  = cfg && en && !sel;
            // trigger: high for edges act_at .. act_at+STRETCH-1
            if (act_at >= 0 && k_cyc == act_at + STRETCH) begin
                m_x      = 1'b0;
                next_acc = k_cyc + longint'(holdoff) + 2;
                act_at   = -1;
            end else if (act_at < 0 && k_cyc >= next_acc && te) begin
                act_at = k_cyc;
                m_x    = 1'b1;
            end
        end
        ext_h.push_back(rst ? 1'b0 : ext);   void'(ext_h.pop_front());
        trig_h.push_back(rst ? 1'b0 : trig); void'(trig_h.pop_front());
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("time_tick", 64'(tick_o), 64'(m_tick));
        check("xtrigger", 64'(xtrig_o), 64'(m_x));
        check("cfg_err", 64'(cfg_o), 64'(m_cfg));
`ifdef DFD_TIME_TICK_GEN_STATS_EN
        check("tick_count", 64'(count_o), 64'(m_cnt));
`else
        check("tick_count", 64'(count_o), 64'h0);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first, cnt, last, rise_at;
        rst = 1; en = 0; sel = 0; inc = 1; mod = 4; ext = 0; trig = 0;
        holdoff = 5; clr = 0;
        cyc(3);
        check("rst_tick", 64'(tick_o), 64'h0);
        check("rst_xtrig", 64'(xtrig_o), 64'h0);
        check("rst_cfg", 64'(cfg_o), 64'h0);
        check("rst_count", 64'(count_o), 64'h0);
        rst = 0;
        cyc(2);

        // 1: inc=1 mod=4, first tick 5 cycles after entry, then every 4th
        en = 1; first = 0;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            if (tick_o && first == 0) first = n;
            check("t1_tick", 64'(tick_o), 64'((n >= 5 && (n - 5) % 4 == 0) ? 1 : 0));
        end
        check("t1_first", 64'(first), 64'd5);
        en = 0; cyc(2);

        // 2: inc=3 mod=8, 800 accumulation cycles -> 300 ticks, gaps 2 or 3
        clr = 1; cyc(1); clr = 0;
        inc = 3; mod = 8; en = 1; cnt = 0; last = 0;
        for (int n = 1; n <= 801; n++) begin
            @(negedge clk);
            if (tick_o) begin
                cnt++;
                if (last > 0) check("t2_gap", 64'((n - last == 2 || n - last == 3) ? 1 : 0), 64'd1);
                last = n;
            end
        end
        check("t2_ticks", 64'(cnt), 64'd300);
        en = 0;
        @(negedge clk);
`ifdef DFD_TIME_TICK_GEN_STATS_EN
        check("t2_count", 64'(count_o), 64'd300);
`else
        check("t2_count", 64'(count_o), 64'd0);
`endif
        cyc(2);

        // 3: illegal configurations, then inc==mod
        inc = 5; mod = 4; en = 1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check("t3_err_a", 64'(cfg_o), 64'd1);
            check("t3_notick_a", 64'(tick_o), 64'd0);
        end
        mod = 0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            check("t3_err_b", 64'(cfg_o), 64'd1);
            check("t3_notick_b", 64'(tick_o), 64'd0);
        end
        inc = 4; mod = 4;
        @(negedge clk);
        check("t3_err_clear", 64'(cfg_o), 64'd0);
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            check("t3_every", 64'(tick_o), 64'd1);
        end
        en = 0; cyc(2);

        // 4: external tick, 4-cycle latency per rising edge
        inc = 0; mod = 4; sel = 1; ext = 0; en = 1;
        cyc(6);
        rise_at = -100;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            check("t4_ext", 64'(tick_o), 64'((n - rise_at == 4) ? 1 : 0));
            if (n % 10 == 0) begin
                ext = ~ext;
                if (ext) rise_at = n;
            end
        end
        // mode flip with an edge in flight: no spurious tick
        ext = 1; sel = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            check("t4_flip", 64'(tick_o), 64'd0);
        end
        en = 0; ext = 0; cyc(4);

        // 5: stretch 2, holdoff 5; edge at 6 dropped, edge at 20 accepted
        holdoff = 5; trig = 0; cyc(8);
        for (int n = 0; n < 30; n++) begin
            case (n)
                0, 6, 20: trig = 1;
                3, 9, 23: trig = 0;
                default: ;
            endcase
            @(negedge clk);
            check("t5_xtrig", 64'(xtrig_o),
                  64'(((n + 1) == 4 || (n + 1) == 5 || (n + 1) == 24 || (n + 1) == 25) ? 1 : 0));
        end
        cyc(4);

        // 6: reset mid-pulse and at 3/4 accumulation
        holdoff = 0; inc = 1; mod = 4; sel = 0;
        en = 1; trig = 1;
        cyc(4);
        check("t6_pulse_up", 64'(xtrig_o), 64'd1);
        rst = 1; trig = 0;
        @(negedge clk);
        check("t6_rst_tick", 64'(tick_o), 64'd0);
        check("t6_rst_xtrig", 64'(xtrig_o), 64'd0);
        rst = 0;
        for (int n = 6; n <= 10; n++) begin
            @(negedge clk);
            check("t6_period", 64'(tick_o), 64'((n == 10) ? 1 : 0));
        end

        // randomized phase
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 59) == 0) sel = ~sel;
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    mod = ACC_W'($urandom_range(0, 1000));
                    inc = ACC_W'($urandom_range(0, 1000));
                end else begin
                    mod = ACC_W'($urandom_range(0, 12));
                    inc = ACC_W'($urandom_range(0, 14));
                end
            end
            if ($urandom_range(0, 3) == 0) ext = ~ext;
            if ($urandom_range(0, 4) == 0) trig = ~trig;
            if ($urandom_range(0, 19) == 0) holdoff = HOLD_W'($urandom_range(0, 7));
            @(negedge clk);
        end
        rst = 0; clr = 0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
